// File: rtl/spi_queue.sv
`default_nettype none
// ============================================================================
// Module      : spi_queue
// Description : Bus-side queueing front end for an SPI byte shifter. The CPU
//               pushes bytes into a TX FIFO; an engine hands them one at a
//               time to the shifter (start/busy handshake) and collects each
//               received byte into an RX FIFO. Optional drain interrupt.
// Ports       : clock_sys, reset      - clock, async active-high reset
//               addr/data/rw/cs       - CPU bus (cs active low)
//               data_out/data_out_en  - combinational read data and enable
//               xfer_data/xfer_start  - byte and start pulse to the shifter
//               xfer_busy/xfer_result - shifter status and received byte
//               irq                   - level interrupt (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_queue #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] ADDR_BASE = 8'h12
) (
    input  logic       clock_sys,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    input  logic       rw,
    input  logic       cs,
    output logic [7:0] data_out,
    output logic       data_out_en,
    output logic [7:0] xfer_data,
    output logic       xfer_start,
    input  logic       xfer_busy,
    input  logic [7:0] xfer_result,
    output logic       irq
);

    localparam int              c_aw        = $clog2(DEPTH);
    localparam int              c_cw        = c_aw + 1;
    localparam logic [c_cw-1:0] c_full      = c_cw'(DEPTH);
    localparam logic [7:0]      c_addr_data = ADDR_BASE;
    localparam logic [7:0]      c_addr_ctrl = ADDR_BASE + 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        tx_mem_q [DEPTH];
    logic [7:0]        rx_mem_q [DEPTH];
    logic [c_aw-1:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [c_aw-1:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [c_cw-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic              xfer_start_q, xfer_start_d;
    logic [7:0]        xfer_data_q, xfer_data_d;
    logic              irq_en_q, irq_en_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic              discard_q, discard_d;
    logic              irq_q, irq_d;

    logic w_sel_data, w_sel_ctrl, w_wr_data, w_rd_data, w_wr_ctrl, w_rd_status;
    logic w_flush, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, w_busy;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_done;
    logic [7:0] w_status;

    // ---------------- bus decode ----------------
    assign w_sel_data  = ~cs & (addr == c_addr_data);
    assign w_sel_ctrl  = ~cs & (addr == c_addr_ctrl);
    assign w_wr_data   = w_sel_data & ~rw;
    assign w_rd_data   = w_sel_data & rw;
    assign w_wr_ctrl   = w_sel_ctrl & ~rw;
    assign w_rd_status = w_sel_ctrl & rw;
    assign w_flush     = w_wr_ctrl & data[1];

    assign w_tx_full   = (tx_cnt_q == c_full);
    assign w_tx_empty  = (tx_cnt_q == '0);
    assign w_rx_full   = (rx_cnt_q == c_full);
    assign w_rx_empty  = (rx_cnt_q == '0);
    assign w_busy      = (state_q != ST_IDLE);

    // Transfer completes on the first cycle busy is seen low in WAIT_DONE.
    assign w_done      = (state_q == ST_WAIT_DONE) & ~xfer_busy;

    // Fullness uses the pre-edge count, so a write racing a pop from a full
    // TX FIFO is still dropped. Flush overrides any same-cycle pop/push.
    assign w_tx_push   = w_wr_data & ~w_tx_full;
    assign w_tx_pop    = (state_q == ST_START) & ~w_tx_empty & ~w_flush;
    assign w_rx_push   = w_done & ~discard_q & ~w_flush;
    assign w_rx_pop    = w_rd_data & ~w_rx_empty;

    assign w_status    = {irq_q, irq_en_q, tx_ovf_q, w_busy,
                          w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

    // ---------------- FIFO pointers and counts ----------------
    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;

        if (w_tx_push) tx_wr_d = tx_wr_q + c_aw'(1);
        if (w_tx_pop)  tx_rd_d = tx_rd_q + c_aw'(1);
        case ({w_tx_push, w_tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + c_cw'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - c_cw'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase

        if (w_rx_push) rx_wr_d = rx_wr_q + c_aw'(1);
        if (w_rx_pop)  rx_rd_d = rx_rd_q + c_aw'(1);
        case ({w_rx_push, w_rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + c_cw'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - c_cw'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase

        if (w_flush) begin
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            tx_cnt_d = '0;
            rx_wr_d  = '0;
            rx_rd_d  = '0;
            rx_cnt_d = '0;
        end
    end

    // ---------------- control bits and interrupt ----------------
    always_comb begin
        irq_en_d  = irq_en_q;
        tx_ovf_d  = tx_ovf_q;
        discard_d = discard_q;

        if (w_wr_ctrl) begin
            irq_en_d = data[0];
            if (data[5]) tx_ovf_d = 1'b0;
        end
        if (w_wr_data && w_tx_full) tx_ovf_d = 1'b1;

        // A flush landing on the completion cycle already suppresses that
        // push, so discard must not linger into the next transfer.
        if (w_done) begin
            discard_d = 1'b0;
        end else if (w_flush && w_busy) begin
            discard_d = 1'b1;
        end

        irq_d = irq_en_q & w_tx_empty & ~w_busy & ~w_rx_empty;
    end

    // ---------------- transfer engine ----------------
    always_comb begin
        state_d      = state_q;
        xfer_start_d = 1'b0;
        xfer_data_d  = xfer_data_q;
        case (state_q)
            ST_IDLE: begin
                // Nothing is in flight here, so RX space is simply !rx_full.
                if (!w_tx_empty && !w_rx_full && !w_flush) begin
                    state_d      = ST_START;
                    xfer_start_d = 1'b1;
                    xfer_data_d  = tx_mem_q[tx_rd_q];
                end
            end
            ST_START:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (xfer_busy)  state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!xfer_busy) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_sys or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tx_wr_q      <= '0;
            tx_rd_q      <= '0;
            tx_cnt_q     <= '0;
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            rx_cnt_q     <= '0;
            xfer_start_q <= 1'b0;
            xfer_data_q  <= 8'h00;
            irq_en_q     <= 1'b0;
            tx_ovf_q     <= 1'b0;
            discard_q    <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_wr_q      <= tx_wr_d;
            tx_rd_q      <= tx_rd_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_wr_q      <= rx_wr_d;
            rx_rd_q      <= rx_rd_d;
            rx_cnt_q     <= rx_cnt_d;
            xfer_start_q <= xfer_start_d;
            xfer_data_q  <= xfer_data_d;
            irq_en_q     <= irq_en_d;
            tx_ovf_q     <= tx_ovf_d;
            discard_q    <= discard_d;
            irq_q        <= irq_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counts.
    always_ff @(posedge clock_sys) begin
        if (w_tx_push) tx_mem_q[tx_wr_q] <= data;
        if (w_rx_push) rx_mem_q[rx_wr_q] <= xfer_result;
    end

    // ---------------- outputs ----------------
    always_comb begin
        data_out = 8'h00;
        if (w_rd_data && !w_rx_empty) begin
            data_out = rx_mem_q[rx_rd_q];
        end else if (w_rd_status) begin
            data_out = w_status;
        end
    end

    assign data_out_en = ~cs & rw & ((addr == c_addr_data) | (addr == c_addr_ctrl));
    assign xfer_start  = xfer_start_q;
    assign xfer_data   = xfer_data_q;
    assign irq         = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_queue
// Description : Self-checking bench for spi_queue. A behavioural shifter
//               answers each start pulse with a random result; queues hold
//               the bytes expected on the wire and in the RX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_queue;

    localparam logic [7:0] A_DATA = 8'h12;
    localparam logic [7:0] A_CTRL = 8'h13;

    logic       clk = 1'b0;
    logic       reset, rw, cs, xfer_busy, xfer_start, data_out_en, irq;
    logic [7:0] addr, data, data_out, xfer_data, xfer_result;

    always #5 clk = ~clk;

    spi_queue #(.DEPTH(8), .ADDR_BASE(8'h12)) dut (
        .clock_sys   (clk),
        .reset       (reset),
        .addr        (addr),
        .data        (data),
        .rw          (rw),
        .cs          (cs),
        .data_out    (data_out),
        .data_out_en (data_out_en),
        .xfer_data   (xfer_data),
        .xfer_start  (xfer_start),
        .xfer_busy   (xfer_busy),
        .xfer_result (xfer_result),
        .irq         (irq)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    int         xfer_cnt = 0;
    int         done_cnt = 0;
    bit         drop_next = 0, shifter_off = 0, man_busy = 0, in_busy = 0, saw_ff = 0;
    int         sh_mode = 0;          // 0 random, 1 fixed 16 cycles/sh_res, 2 long
    logic [7:0] sh_res = 8'h00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Behavioural SPI shifter
    initial begin : shifter
        logic [7:0] res;
        int dly, len;
        xfer_busy   = 1'b0;
        xfer_result = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (shifter_off) begin
                xfer_busy = man_busy;
            end else if (xfer_start === 1'b1 && !reset) begin
                xfer_cnt++;
                if (xfer_data == 8'hFF) saw_ff = 1;
                check("xfer_pending", {7'd0, exp_tx.size() != 0}, 8'd1);
                if (exp_tx.size() != 0) check("xfer_data", xfer_data, exp_tx.pop_front());
                dly = 1 + int'($urandom % 2);
                len = (sh_mode == 1) ? 16 : (sh_mode == 2) ? 30 : 3 + int'($urandom % 3);
                res = (sh_mode == 1) ? sh_res : 8'($urandom);
                for (int i = 0; i < dly; i++) begin
                    @(posedge clk); #1;
                    if (i == 0) check("xfer_start_pulse", {7'd0, xfer_start}, 8'd0);
                end
                xfer_busy = 1'b1;
                in_busy   = 1;
                repeat (len) begin @(posedge clk); #1; end
                xfer_result = res;
                xfer_busy   = 1'b0;
                in_busy     = 0;
                done_cnt++;
                if (drop_next) drop_next = 0;
                else exp_rx.push_back(res);
            end
        end
    end

    // Bus helpers: entered and left at posedge+1
    task automatic bus(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] q, output logic en);
        cs = 1'b0; rw = ~wr; addr = a; data = d;
        @(negedge clk);
        q  = data_out;
        en = data_out_en;
        @(posedge clk); #1;
        cs = 1'b1; rw = 1'b1; addr = 8'h00; data = 8'h00;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] q; logic en;
        bus(1'b1, a, d, q, en);
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] q);
        logic en;
        bus(1'b0, a, 8'h00, q, en);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input int n, input string tag);
        int t = 0;
        do begin @(negedge clk); t++; end while (done_cnt < n && t < 3000);
        check(tag, {7'd0, done_cnt >= n}, 8'd1);
    endtask

    // Write a byte once TX reports space; TX can only drain in between.
    task automatic wr_safe(input logic [7:0] b);
        logic [7:0] s;
        int t = 0;
        do begin rd_reg(A_CTRL, s); t++; end while (s[0] && t < 500);
        exp_tx.push_back(b);
        wr_reg(A_DATA, b);
    endtask

    task automatic read_rx_check(input string tag);
        logic [7:0] s, q;
        int t = 0;
        do begin rd_reg(A_CTRL, s); t++; end while (s[3] && t < 500);
        rd_reg(A_DATA, q);
        check({tag, "_pending"}, {7'd0, exp_rx.size() != 0}, 8'd1);
        if (exp_rx.size() != 0) check(tag, q, exp_rx.pop_front());
    endtask

    initial begin : stim
        logic [7:0] s, q;
        logic       en;
        int         bx, bd, t;

        reset = 1'b1; cs = 1'b1; rw = 1'b1; addr = 8'h00; data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(1);

        // Reset state
        check("rst_xfer_start", {7'd0, xfer_start}, 8'd0);
        check("rst_xfer_data", xfer_data, 8'h00);
        check("rst_irq", {7'd0, irq}, 8'd0);
        rd_reg(A_CTRL, s);
        check("rst_status", s, 8'h0A);

        // Single transfer, fixed shifter answer
        sh_mode = 1; sh_res = 8'h3C;
        exp_tx.push_back(8'hA5);
        wr_reg(A_DATA, 8'hA5);
        check("start_early", {7'd0, xfer_start}, 8'd0);
        idle(1);
        check("start_latency", {7'd0, xfer_start}, 8'd1);
        check("start_data", xfer_data, 8'hA5);
        wait_done(1, "t1_done");
        @(posedge clk); #1;
        rd_reg(A_DATA, q);
        check("t1_rx_3c", q, 8'h3C);
        if (exp_rx.size() != 0) void'(exp_rx.pop_front());
        rd_reg(A_CTRL, s);
        check("t1_status", s, 8'h0A);
        sh_mode = 0;

        // Unmapped address
        bus(1'b0, 8'h40, 8'h00, q, en);
        check("other_addr_data", q, 8'h00);
        check("other_addr_en", {7'd0, en}, 8'd0);

        // Empty RX read leaves pointers alone
        bus(1'b0, A_DATA, 8'h00, q, en);
        check("empty_rd_data", q, 8'h00);
        check("empty_rd_en", {7'd0, en}, 8'd1);
        bd = done_cnt;
        for (int i = 0; i < 2; i++) wr_safe(8'($urandom));
        wait_done(bd + 2, "t2_done");
        for (int i = 0; i < 2; i++) read_rx_check("t2_rx");

        // RX full stall, then TX overflow
        bx = xfer_cnt; bd = done_cnt;
        for (int i = 0; i < 10; i++) wr_safe(8'($urandom & 32'h7F));
        wait_done(bd + 8, "t3_done8");
        idle(30);
        check("stall_xfers", 8'(xfer_cnt - bx), 8'd8);
        rd_reg(A_CTRL, s);
        check("stall_status", s, 8'h04);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            b = 8'($urandom & 32'h7F);
            exp_tx.push_back(b);
            wr_reg(A_DATA, b);
        end
        rd_reg(A_CTRL, s);
        check("tx_seven", s, 8'h04);
        begin
            logic [7:0] b;
            b = 8'($urandom & 32'h7F);
            exp_tx.push_back(b);
            wr_reg(A_DATA, b);
        end
        rd_reg(A_CTRL, s);
        check("tx_full", s, 8'h05);
        wr_reg(A_DATA, 8'hFF);
        rd_reg(A_CTRL, s);
        check("tx_ovf_set", s, 8'h25);
        wr_reg(A_CTRL, 8'h20);
        rd_reg(A_CTRL, s);
        check("tx_ovf_clr", s, 8'h05);
        read_rx_check("t3_rx");
        t = 0;
        while (xfer_cnt < bx + 9 && t < 200) begin idle(1); t++; end
        check("ninth_start", 8'(xfer_cnt - bx), 8'd9);
        for (int i = 0; i < 15; i++) read_rx_check("t3_rx");
        idle(5);
        check("t3_total", 8'(xfer_cnt - bx), 8'd16);
        check("no_ff_sent", {7'd0, saw_ff}, 8'd0);
        rd_reg(A_CTRL, s);
        check("t3_status", s, 8'h0A);

        // Flush while a result is outstanding
        sh_mode = 2;
        bx = xfer_cnt; bd = done_cnt;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp_tx.push_back(b);
            wr_reg(A_DATA, b);
        end
        t = 0;
        while (!in_busy && t < 50) begin @(negedge clk); t++; end
        check("flush_busy_seen", {7'd0, in_busy}, 8'd1);
        @(posedge clk); #1;
        idle(3);
        exp_tx.delete();
        drop_next = 1;
        wr_reg(A_CTRL, 8'h02);
        rd_reg(A_CTRL, s);
        check("flush_status", s, 8'h1A);
        wait_done(bd + 1, "flush_done");
        @(posedge clk); #1;
        idle(10);
        rd_reg(A_CTRL, s);
        check("flush_after", s, 8'h0A);
        check("flush_xfers", 8'(xfer_cnt - bx), 8'd1);
        check("flush_rx_model", 8'(exp_rx.size()), 8'd0);
        sh_mode = 0;

        // Drain interrupt
        wr_reg(A_CTRL, 8'h01);
        bd = done_cnt;
        for (int i = 0; i < 2; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp_tx.push_back(b);
            wr_reg(A_DATA, b);
        end
        wait_done(bd + 2, "irq_done");
        @(posedge clk); #1;
        check("irq_lag", {7'd0, irq}, 8'd0);
        idle(1);
        check("irq_set", {7'd0, irq}, 8'd1);
        rd_reg(A_CTRL, s);
        check("irq_status", s, 8'hC2);
        read_rx_check("irq_rx");
        read_rx_check("irq_rx");
        idle(1);
        check("irq_clr", {7'd0, irq}, 8'd0);

        // Asynchronous reset during WAIT_BUSY
        shifter_off = 1;
        man_busy    = 0;
        wr_reg(A_DATA, 8'h77);
        t = 0;
        while (xfer_start !== 1'b1 && t < 20) begin idle(1); t++; end
        check("rst_t_start", {7'd0, xfer_start}, 8'd1);
        check("rst_t_data", xfer_data, 8'h77);
        idle(1);
        #2 reset = 1'b1;
        #1;
        check("async_xfer_start", {7'd0, xfer_start}, 8'd0);
        check("async_xfer_data", xfer_data, 8'h00);
        check("async_irq", {7'd0, irq}, 8'd0);
        cs = 1'b0; rw = 1'b1; addr = A_CTRL;
        #1;
        check("async_status", data_out, 8'h0A);
        cs = 1'b1; addr = 8'h00;
        man_busy = 1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        man_busy = 0;
        idle(5);
        rd_reg(A_CTRL, s);
        check("late_busy_ignored", s, 8'h0A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
